// File: rtl/qrd_rls_feed_sched_if.sv
// Sample stream into the QRD-RLS feed scheduler: four regressor taps plus the
// desired signal, carried over a single valid/ready handshake.
interface qrd_rls_feed_sched_if #(
    parameter int DATA_LENGTH = 8
);
    // A sample transfers on a rising clk edge where s_valid && s_ready are both
    // high; the master holds s_valid and data stable until that edge, while
    // s_ready may change in any cycle without waiting for s_valid.
    logic                   s_valid;
    logic                   s_ready;
    logic [DATA_LENGTH-1:0] s_x0;
    logic [DATA_LENGTH-1:0] s_x1;
    logic [DATA_LENGTH-1:0] s_x2;
    logic [DATA_LENGTH-1:0] s_x3;
    logic [DATA_LENGTH-1:0] s_d;

    modport master (
        output s_valid, s_x0, s_x1, s_x2, s_x3, s_d,
        input  s_ready
    );

    modport slave (
        input  s_valid, s_x0, s_x1, s_x2, s_x3, s_d,
        output s_ready
    );
endinterface

// File: rtl/qrd_rls_feed_sched.sv
// Training-run sequencer in front of the 4x4 QRD-RLS systolic array: frames samples,
// drains the pipeline and tags valid error outputs. Optional accumulator: QRD_SCHED_ERRACC_EN.
module qrd_rls_feed_sched #(
    parameter int DATA_LENGTH = 8,
    parameter int PIPE_LAT    = 10,
    parameter int TRAIN_LEN   = 64,
    parameter int CNT_W       = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         freeze,
    qrd_rls_feed_sched_if.slave          s,
    output logic [DATA_LENGTH-1:0]       arr_x0,
    output logic [DATA_LENGTH-1:0]       arr_x1,
    output logic [DATA_LENGTH-1:0]       arr_x2,
    output logic [DATA_LENGTH-1:0]       arr_x3,
    output logic [DATA_LENGTH-1:0]       arr_d,
    output logic                         arr_ready_in,
    input  logic [DATA_LENGTH-1:0]       error_in,
    output logic                         err_valid,
    output logic [DATA_LENGTH-1:0]       err_out,
    output logic [CNT_W-1:0]             sample_cnt,
    output logic                         busy,
    output logic                         done,
    output logic [DATA_LENGTH+CNT_W-1:0] err_acc,
    output logic [1:0]                   fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAIN = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int                 DRAIN_W   = $clog2(PIPE_LAT + 1);
    localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(TRAIN_LEN);
    localparam logic [DRAIN_W-1:0] DRAIN_END = DRAIN_W'(PIPE_LAT);

    state_t              state;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [PIPE_LAT-2:0] tag;
    logic [CNT_W-1:0]    cnt_next;
    logic                accept;
    logic                start_run;

    assign s.s_ready = (state == TRAIN) && !freeze;
    assign accept    = s.s_valid && s.s_ready;
    assign start_run = start && ((state == IDLE) || (state == HOLD));
    assign cnt_next  = sample_cnt + CNT_W'(1);
    assign busy      = (state == TRAIN) || (state == DRAIN);
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            drain_cnt    <= '0;
            sample_cnt   <= '0;
            done         <= 1'b0;
            arr_x0       <= '0;
            arr_x1       <= '0;
            arr_x2       <= '0;
            arr_x3       <= '0;
            arr_d        <= '0;
            arr_ready_in <= 1'b0;
        end else begin
            // Every cycle without an accepted sample feeds a zero bubble.
            arr_x0       <= '0;
            arr_x1       <= '0;
            arr_x2       <= '0;
            arr_x3       <= '0;
            arr_d        <= '0;
            arr_ready_in <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_run) begin
                        state      <= TRAIN;
                        sample_cnt <= '0;
                    end
                end
                TRAIN: begin
                    if (accept) begin
                        arr_x0       <= s.s_x0;
                        arr_x1       <= s.s_x1;
                        arr_x2       <= s.s_x2;
                        arr_x3       <= s.s_x3;
                        arr_d        <= s.s_d;
                        arr_ready_in <= 1'b1;
                        sample_cnt   <= cnt_next;
                        if (cnt_next == LAST_CNT) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    // PIPE_LAT+1 drain cycles so the final tagged error lands before HOLD.
                    if (drain_cnt == DRAIN_END) begin
                        state <= HOLD;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                HOLD: begin
                    if (start_run) begin
                        state      <= TRAIN;
                        sample_cnt <= '0;
                        done       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag shift register plus the err_valid stage gives a PIPE_LAT-deep delay of arr_ready_in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag       <= '0;
            err_valid <= 1'b0;
            err_out   <= '0;
        end else begin
            tag[0] <= arr_ready_in;
            for (int i = 1; i < PIPE_LAT - 1; i++) begin
                tag[i] <= tag[i-1];
            end
            err_valid <= tag[PIPE_LAT-2];
            if (tag[PIPE_LAT-2]) begin
                err_out <= error_in;
            end
        end
    end

`ifdef QRD_SCHED_ERRACC_EN
    localparam int ACC_W = DATA_LENGTH + CNT_W;
    localparam int SUM_W = ACC_W + 1;

    logic [DATA_LENGTH-1:0] err_mag;
    logic [SUM_W-1:0]       acc_sum;

    // Two's complement magnitude; the most-negative code maps to 2^(DATA_LENGTH-1).
    assign err_mag = err_out[DATA_LENGTH-1] ? (~err_out + DATA_LENGTH'(1)) : err_out;
    assign acc_sum = {1'b0, err_acc} + SUM_W'(err_mag);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_acc <= '0;
        end else if (start_run) begin
            err_acc <= '0;
        end else if (err_valid) begin
            err_acc <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        end
    end
`else
    assign err_acc = '0;
`endif

endmodule

// File: tb/tb_qrd_rls_feed_sched.sv
// Scoreboard bench for qrd_rls_feed_sched: directed training runs with freeze,
// mid-run reset and ignored starts; QRD_SCHED_ERRACC_EN adds accumulator runs.
`timescale 1ns/1ps
module tb_qrd_rls_feed_sched;

    localparam int DL  = 8;
    localparam int PL  = 10;
    localparam int TL  = 64;
    localparam int CW  = 8;
    localparam int AW  = DL + CW;
    localparam int AQW = 32 + 5 * DL;
    localparam int EQW = 32 + DL;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          freeze;
    logic [DL-1:0] arr_x0, arr_x1, arr_x2, arr_x3, arr_d;
    logic          arr_ready_in;
    logic [DL-1:0] error_in;
    logic          err_valid;
    logic [DL-1:0] err_out;
    logic [CW-1:0] sample_cnt;
    logic          busy;
    logic          done;
    logic [AW-1:0] err_acc;
    logic [1:0]    fsm_state;

    qrd_rls_feed_sched_if #(.DATA_LENGTH(DL)) s_if ();

    qrd_rls_feed_sched #(
        .DATA_LENGTH(DL),
        .PIPE_LAT   (PL),
        .TRAIN_LEN  (TL),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .freeze      (freeze),
        .s           (s_if),
        .arr_x0      (arr_x0),
        .arr_x1      (arr_x1),
        .arr_x2      (arr_x2),
        .arr_x3      (arr_x3),
        .arr_d       (arr_d),
        .arr_ready_in(arr_ready_in),
        .error_in    (error_in),
        .err_valid   (err_valid),
        .err_out     (err_out),
        .sample_cnt  (sample_cnt),
        .busy        (busy),
        .done        (done),
        .err_acc     (err_acc),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // error_in is either a free-running cycle counter or a constant
    logic          err_const_mode = 1'b0;
    logic [DL-1:0] err_const = '0;
    assign error_in = err_const_mode ? err_const : DL'(cyc);

    // ---------------- scoreboard state ----------------
    int             checks = 0;
    int             failures = 0;
    logic [AQW-1:0] arr_q[$];
    logic [EQW-1:0] err_q[$];
    int             n_acc = 0;
    int             err_pulses = 0;
    int             last_acc_cyc = 0;
    longint         exp_acc = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic logic [DL-1:0] exp_err(input int c);
        if (err_const_mode) return err_const;
        return DL'(c + PL);
    endfunction

    function automatic int mag(input logic [DL-1:0] v);
        if (v[DL-1]) return (1 << DL) - int'(v);
        return int'(v);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic           exp_v;
        logic           exp_e;
        logic [AQW-1:0] ae;
        logic [EQW-1:0] ee;
        exp_v = (arr_q.size() > 0) && (arr_q[0][AQW-1 -: 32] == 32'(cyc));
        chk("arr_ready_in", arr_ready_in, exp_v);
        if (exp_v) begin
            ae = arr_q.pop_front();
            chk("arr_data", {arr_x0, arr_x1, arr_x2, arr_x3, arr_d}, 64'(ae[5*DL-1:0]));
        end else begin
            chk("arr_bubble", {arr_x0, arr_x1, arr_x2, arr_x3, arr_d}, 64'd0);
        end
        exp_e = (err_q.size() > 0) && (err_q[0][EQW-1 -: 32] == 32'(cyc));
        chk("err_valid", err_valid, exp_e);
        if (exp_e) begin
            ee = err_q.pop_front();
            chk("err_out", err_out, 64'(ee[DL-1:0]));
            err_pulses++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [DL-1:0] x0, x1, x2, x3, d);
        logic got;
        got = 1'b0;
        s_if.s_valid = 1'b1;
        s_if.s_x0 = x0;
        s_if.s_x1 = x1;
        s_if.s_x2 = x2;
        s_if.s_x3 = x3;
        s_if.s_d  = d;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (s_if.s_ready === 1'b1) begin
                got = 1'b1;
                n_acc++;
                last_acc_cyc = cyc;
                arr_q.push_back({32'(cyc + 1), x0, x1, x2, x3, d});
                err_q.push_back({32'(cyc + 1 + PL), exp_err(cyc)});
                exp_acc += longint'(mag(exp_err(cyc)));
            end
            @(posedge clk);
            #1;
        end
        chk("send_accept", got, 1'b1);
    endtask

    task automatic feed(input int n, input int base, input int freeze_at, input bit start_mid);
        for (int i = 0; i < n; i++) begin
            if (i == freeze_at) begin
                s_if.s_valid = 1'b1;
                freeze = 1'b1;
                for (int j = 0; j < 5; j++) begin
                    @(negedge clk);
                    chk("freeze_s_ready", s_if.s_ready, 1'b0);
                    chk("freeze_cnt", sample_cnt, i);
                    @(posedge clk);
                    #1;
                    chk("freeze_bubble", arr_ready_in, 1'b0);
                end
                freeze = 1'b0;
            end
            if (start_mid && i == 10) start = 1'b1;
            send(DL'(i + base), ~DL'(i), DL'(i) ^ 8'h5A, DL'(i + 128), DL'(2 * i));
            start = 1'b0;
        end
        s_if.s_valid = 1'b0;
    endtask

    task automatic begin_run();
        n_acc = 0;
        err_pulses = 0;
        exp_acc = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("run_state", fsm_state, 2'd1);
        chk("run_cnt", sample_cnt, 0);
        chk("run_done", done, 1'b0);
        chk("run_busy", busy, 1'b1);
        chk("run_acc_clear", err_acc, 0);
    endtask

    task automatic finish_run(input bit drain_start);
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < PL + 40 && !seen; t++) begin
            @(negedge clk);
            if (cyc == last_acc_cyc + 1) begin
                chk("drain_state", fsm_state, 2'd2);
                chk("drain_s_ready", s_if.s_ready, 1'b0);
                if (drain_start) start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) seen = 1'b1;
        end
        start = 1'b0;
        chk("done_latency", cyc, last_acc_cyc + PL + 2);
        chk("hold_state", fsm_state, 2'd3);
        chk("hold_cnt", sample_cnt, TL);
        chk("hold_busy", busy, 1'b0);
        chk("accepts", n_acc, TL);
        chk("err_pulses", err_pulses, TL);
        chk("err_pending", err_q.size(), 0);
`ifdef QRD_SCHED_ERRACC_EN
        chk("err_acc", err_acc, 64'(exp_acc));
`else
        chk("err_acc", err_acc, 0);
`endif
    endtask

    task automatic idle_valid(input int n, input int exp_cnt);
        s_if.s_valid = 1'b1;
        s_if.s_x0 = 8'hEE;
        s_if.s_d  = 8'hEE;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_s_ready", s_if.s_ready, 1'b0);
            chk("idle_cnt", sample_cnt, exp_cnt);
        end
        s_if.s_valid = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_s_ready"}, s_if.s_ready, 1'b0);
        chk({tag, "_arr"}, {arr_x0, arr_x1, arr_x2, arr_x3, arr_d}, 64'd0);
        chk({tag, "_arr_ready_in"}, arr_ready_in, 1'b0);
        chk({tag, "_err_valid"}, err_valid, 1'b0);
        chk({tag, "_err_out"}, err_out, 0);
        chk({tag, "_sample_cnt"}, sample_cnt, 0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err_acc"}, err_acc, 0);
        chk({tag, "_state"}, fsm_state, 2'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        freeze = 1'b0;
        s_if.s_valid = 1'b0;
        s_if.s_x0 = '0;
        s_if.s_x1 = '0;
        s_if.s_x2 = '0;
        s_if.s_x3 = '0;
        s_if.s_d  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        rst_n = 1'b1;

        idle_valid(3, 0);

        // run 1: 64 back-to-back samples, x0=i, d=2i
        begin_run();
        feed(TL, 0, -1, 1'b0);
        finish_run(1'b0);

        idle_valid(2, TL);

        // run 2: freeze for 5 cycles at sample 20, start pulses in TRAIN and DRAIN
        begin_run();
        feed(TL, 40, 20, 1'b1);
        finish_run(1'b1);

        // run 3: reset after sample 30, then a clean restart
        begin_run();
        feed(30, 7, -1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        arr_q.delete();
        err_q.delete();
        check_reset("midrst");
        repeat (PL + 4) @(posedge clk);
        #1;
        chk("post_rst_state", fsm_state, 2'd0);
        chk("post_rst_cnt", sample_cnt, 0);
        begin_run();
        feed(TL, 3, -1, 1'b0);
        finish_run(1'b0);

`ifdef QRD_SCHED_ERRACC_EN
        err_const_mode = 1'b1;
        err_const = 8'hFD;
        begin_run();
        feed(TL, 0, -1, 1'b0);
        finish_run(1'b0);
        chk("acc_minus3", err_acc, 192);

        err_const = 8'h80;
        begin_run();
        feed(TL, 0, -1, 1'b0);
        finish_run(1'b0);
        chk("acc_minus128", err_acc, 8192);
        err_const_mode = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("arr_q_drained", arr_q.size(), 0);
        chk("err_q_drained", err_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
